// File: rtl/fifo_pop_stage.sv
// ---------------------------------------------------------------------------
// fifo_pop_stage
//
// Consumer stage for a 4-entry FIFO whose read data is combinational. The
// stage pops the FIFO, captures the word in the same cycle, and re-presents
// it on a val/rdy output through a 2-entry skid buffer. The FIFO read enable
// looks only at registered occupancy, fifo_empty_i, clear_i and reset, so
// there is no combinational path from out_rdy or FIFO data to the pop.
//
// Optional feature: define FIFO_POP_STAGE_STATS_EN to build the handshake
// and stall counters. Without it, pop_count_o and stall_count_o are tied
// to zero and no counter flops exist.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-low reset
//   fifo_empty_i   FIFO empty flag
//   fifo_rd_data_i FIFO read data, valid when fifo_rd_en_o=1
//   fifo_rd_en_o   pop request to the FIFO
//   clear_i        synchronous flush of the skid buffer
//   out_val        output message valid
//   out_rdy        downstream ready
//   out_msg        output message (head entry)
//   pop_count_o    number of output handshakes (wrapping)
//   stall_count_o  cycles with out_val=1 and out_rdy=0 (saturating)
// ---------------------------------------------------------------------------
module fifo_pop_stage #(
   parameter int DATA_W = 32,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty_i,
   input  logic [DATA_W-1:0] fifo_rd_data_i,
   output logic              fifo_rd_en_o,
   input  logic              clear_i,
   output logic              out_val,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_msg,
   output logic [STAT_W-1:0] pop_count_o,
   output logic [STAT_W-1:0] stall_count_o
);

   logic [DATA_W-1:0] ent_r [2];
   logic              hd_r;
   logic              tl_r;
   logic [1:0]        cnt_r;
   logic              push_s;
   logic              pop_s;

   // Reset is folded in so the pop request drops immediately, before any
   // clock edge, when reset is asserted mid-stream.
   assign fifo_rd_en_o = reset && !fifo_empty_i && (cnt_r != 2'd2) && !clear_i;
   assign push_s       = fifo_rd_en_o;
   assign pop_s        = out_val && out_rdy;

   assign out_val = (cnt_r != 2'd0);
   assign out_msg = (cnt_r != 2'd0) ? ent_r[hd_r] : {DATA_W{1'b0}};

   // Skid buffer storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r    <= 2'd0;
         hd_r     <= 1'b0;
         tl_r     <= 1'b0;
         ent_r[0] <= {DATA_W{1'b0}};
         ent_r[1] <= {DATA_W{1'b0}};
      end else if (clear_i) begin
         // Entry contents are left as they are; occupancy 0 hides them.
         cnt_r <= 2'd0;
         hd_r  <= 1'b0;
         tl_r  <= 1'b0;
      end else begin
         if (push_s) begin
            ent_r[tl_r] <= fifo_rd_data_i;
            tl_r        <= tl_r + 1'b1;
         end
         if (pop_s) begin
            hd_r <= hd_r + 1'b1;
         end
         // Push is blocked at 2 and pop needs cnt!=0, so cnt stays in 0..2.
         cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
      end
   end

`ifdef FIFO_POP_STAGE_STATS_EN
   logic [STAT_W-1:0] pop_cnt_r;
   logic [STAT_W-1:0] stall_cnt_r;
   logic              stall_s;

   assign stall_s = out_val && !out_rdy;

   // Handshake counter wraps; stall counter saturates at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop_cnt_r   <= {STAT_W{1'b0}};
         stall_cnt_r <= {STAT_W{1'b0}};
      end else if (clear_i) begin
         pop_cnt_r   <= {STAT_W{1'b0}};
         stall_cnt_r <= {STAT_W{1'b0}};
      end else begin
         if (pop_s) begin
            pop_cnt_r <= pop_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end
         if (stall_s && (stall_cnt_r != {STAT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign pop_count_o   = pop_cnt_r;
   assign stall_count_o = stall_cnt_r;
`else
   assign pop_count_o   = {STAT_W{1'b0}};
   assign stall_count_o = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_pop_stage.sv
module tb_fifo_pop_stage;

   logic        clk;
   logic        reset;
   logic        fifo_empty_i;
   logic [31:0] fifo_rd_data_i;
   logic        fifo_rd_en_o;
   logic        clear_i;
   logic        out_val;
   logic        out_rdy;
   logic [31:0] out_msg;
   logic [15:0] pop_count_o;
   logic [15:0] stall_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] fq[$];   // words still held in the upstream FIFO
   logic [31:0] sb[$];   // words expected to be inside the stage, in order

`ifdef FIFO_POP_STAGE_STATS_EN
   localparam logic [31:0] EXP_POPS   = 32'd5;
   localparam logic [31:0] EXP_STALLS = 32'd3;
`else
   localparam logic [31:0] EXP_POPS   = 32'd0;
   localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

   typedef struct {
      logic        empty;
      logic [31:0] data;
      logic        rdy;
      logic        clr;
      logic        exp_en;
      logic        exp_val;
      logic [31:0] exp_msg;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs[NV];

   fifo_pop_stage #(.DATA_W(32), .STAT_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .fifo_empty_i(fifo_empty_i),
      .fifo_rd_data_i(fifo_rd_data_i),
      .fifo_rd_en_o(fifo_rd_en_o),
      .clear_i(clear_i),
      .out_val(out_val),
      .out_rdy(out_rdy),
      .out_msg(out_msg),
      .pop_count_o(pop_count_o),
      .stall_count_o(stall_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock with a behavioural FIFO upstream and an order scoreboard.
   task automatic mcycle(input logic rdy, input logic clr, output logic hs, output logic [31:0] msg);
      logic val_exp;
      logic en_exp;
      out_rdy        = rdy;
      clear_i        = clr;
      fifo_empty_i   = (fq.size() == 0);
      fifo_rd_data_i = (fq.size() != 0) ? fq[0] : 32'h0;
      #1;
      val_exp = (sb.size() != 0);
      en_exp  = (fq.size() != 0) && (sb.size() < 2) && !clr;
      check("m_val", {31'd0, out_val}, {31'd0, val_exp});
      check("m_rd_en", {31'd0, fifo_rd_en_o}, {31'd0, en_exp});
      if (val_exp) check("m_order", out_msg, sb[0]);
      else         check("m_msg_zero", out_msg, 32'h0);
      hs  = out_val && rdy && !clr;
      msg = out_msg;
      if (clr) begin
         sb.delete();
      end else begin
         if (out_val && rdy && sb.size() != 0) void'(sb.pop_front());
         if (fifo_rd_en_o && fq.size() != 0) sb.push_back(fq.pop_front());
      end
      check("m_occ_le2", {31'd0, (sb.size() <= 2)}, 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic        hs;
      logic [31:0] msg;
      logic [31:0] exp_next;

      // empty data rdy clr | en val msg
      vecs[0]  = '{1'b0, 32'hA0000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'hA0000002, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0000001};
      vecs[2]  = '{1'b0, 32'hA0000003, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0000002};
      vecs[3]  = '{1'b0, 32'hA0000004, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0000003};
      vecs[4]  = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hA0000004};
      vecs[5]  = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'hB0000001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 32'hB0000002, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB0000001};
      vecs[8]  = '{1'b0, 32'hB0000003, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB0000001};
      vecs[9]  = '{1'b0, 32'hB0000003, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB0000001};
      vecs[10] = '{1'b0, 32'hB0000003, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB0000001};
      vecs[11] = '{1'b0, 32'hB0000003, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0000002};
      vecs[12] = '{1'b0, 32'hB0000004, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0000003};
      vecs[13] = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hB0000004};
      vecs[14] = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 32'h00000022, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000011};
      vecs[17] = '{1'b0, 32'h00000033, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000011};
      vecs[18] = '{1'b0, 32'h00000033, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000011};
      vecs[19] = '{1'b0, 32'h00000033, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[20] = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h00000033};
      vecs[21] = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

      // Reset asserted from time 0 with a non-empty FIFO presented.
      reset          = 1'b0;
      fifo_empty_i   = 1'b0;
      fifo_rd_data_i = 32'hDEADBEEF;
      clear_i        = 1'b0;
      out_rdy        = 1'b1;
      #1;
      check("rst_val", {31'd0, out_val}, 32'd0);
      check("rst_msg", out_msg, 32'h0);
      check("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
      check("rst_pops", {16'd0, pop_count_o}, 32'd0);
      check("rst_stalls", {16'd0, stall_count_o}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed table: streaming, backpressure at cnt=2, clear.
      for (int i = 0; i < NV; i++) begin
         fifo_empty_i   = vecs[i].empty;
         fifo_rd_data_i = vecs[i].data;
         out_rdy        = vecs[i].rdy;
         clear_i        = vecs[i].clr;
         #1;
         check($sformatf("vec%0d_rd_en", i), {31'd0, fifo_rd_en_o}, {31'd0, vecs[i].exp_en});
         check($sformatf("vec%0d_val", i), {31'd0, out_val}, {31'd0, vecs[i].exp_val});
         check($sformatf("vec%0d_msg", i), out_msg, vecs[i].exp_msg);
         @(posedge clk);
         @(negedge clk);
      end
      clear_i = 1'b0;

      // Alternating ready with words 0..7.
      for (int i = 0; i < 8; i++) fq.push_back(i);
      exp_next = 32'd0;
      for (int i = 0; i < 40 && (fq.size() != 0 || sb.size() != 0); i++) begin
         mcycle((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, hs, msg);
         if (hs) begin
            check("alt_seq", msg, exp_next);
            exp_next++;
         end
      end
      check("alt_count", exp_next, 32'd8);

      // Asynchronous reset between clock edges with one word buffered.
      fq.push_back(32'hC0000001);
      fq.push_back(32'hC0000002);
      fq.push_back(32'hC0000003);
      mcycle(1'b0, 1'b0, hs, msg);
      fifo_empty_i   = 1'b0;
      fifo_rd_data_i = fq[0];
      #1;
      check("pre_rst_val", {31'd0, out_val}, 32'd1);
      check("pre_rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_val", {31'd0, out_val}, 32'd0);
      check("mid_rst_msg", out_msg, 32'h0);
      check("mid_rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
      fq.delete();
      sb.delete();
      @(negedge clk);
      reset = 1'b1;

      // Statistics: 5 handshakes and 3 stall cycles.
      for (int i = 0; i < 5; i++) fq.push_back(32'hD0000000 + i);
      for (int i = 0; i < 9; i++) begin
         mcycle((i < 4) ? 1'b0 : 1'b1, 1'b0, hs, msg);
      end
      check("stat_pops", {16'd0, pop_count_o}, EXP_POPS);
      check("stat_stalls", {16'd0, stall_count_o}, EXP_STALLS);
      mcycle(1'b0, 1'b1, hs, msg);
      check("stat_clr_pops", {16'd0, pop_count_o}, 32'd0);
      check("stat_clr_stalls", {16'd0, stall_count_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
